// File: rtl/ibuf_pkg.sv
// Shared definitions for the instruction buffer.
//   exception_t  : fetch exception codes (ADEF/TLBR/PIF/PPI).
//   ibuf_entry_t : one buffered instruction with PC, prediction and
//                  fetch-exception fields.
package ibuf_pkg;

  typedef enum logic [5:0] {
    PIF  = 6'h03,
    PPI  = 6'h07,
    ADEF = 6'h08,
    TLBR = 6'h3f
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        have_exception;
    exception_t  exception_type;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_if.sv
// Fetch/decode side bundle of the instruction buffer.
//   master : driven by fetch/decode (in_*, flush, pop_size), observes the rest
//   slave  : the buffer itself (drives ready and out_*)
//
// Handshake: fetch may push in_size (0..2) entries in a cycle where ready was
// high at the start of that cycle; ready high guarantees 4 free entries.
// Decode samples out_*1/out_*2 while out_valid1/out_valid2 are high and
// reports how many it consumed in the same cycle on pop_size (0..2); the pop
// takes effect at the next clock edge. flush discards everything, including
// the same-cycle push and pop.
interface ibuf_if;
  import ibuf_pkg::*;

  logic [1:0]  in_size;
  logic        ready;
  logic [31:0] in_pc1, in_pc2;
  logic [31:0] in_inst1, in_inst2;
  logic        in_pred_taken1, in_pred_taken2;
  logic [31:0] in_pred_target1, in_pred_target2;
  logic        in_have_exception;
  exception_t  in_exception_type;
  logic        flush;
  logic [1:0]  pop_size;

  logic        out_valid1, out_valid2;
  logic [31:0] out_pc1, out_pc2;
  logic [31:0] out_inst1, out_inst2;
  logic        out_pred_taken1, out_pred_taken2;
  logic [31:0] out_pred_target1, out_pred_target2;
  logic        out_have_exception1, out_have_exception2;
  exception_t  out_exception_type1, out_exception_type2;

  modport master (
    output in_size, in_pc1, in_pc2, in_inst1, in_inst2,
           in_pred_taken1, in_pred_taken2, in_pred_target1, in_pred_target2,
           in_have_exception, in_exception_type, flush, pop_size,
    input  ready, out_valid1, out_valid2, out_pc1, out_pc2, out_inst1, out_inst2,
           out_pred_taken1, out_pred_taken2, out_pred_target1, out_pred_target2,
           out_have_exception1, out_have_exception2,
           out_exception_type1, out_exception_type2
  );

  modport slave (
    input  in_size, in_pc1, in_pc2, in_inst1, in_inst2,
           in_pred_taken1, in_pred_taken2, in_pred_target1, in_pred_target2,
           in_have_exception, in_exception_type, flush, pop_size,
    output ready, out_valid1, out_valid2, out_pc1, out_pc2, out_inst1, out_inst2,
           out_pred_taken1, out_pred_taken2, out_pred_target1, out_pred_target2,
           out_have_exception1, out_have_exception2,
           out_exception_type1, out_exception_type2
  );

endinterface

// File: rtl/ibuf.sv
// Instruction buffer between fetch and the dual-issue decoder.
// Circular array of DEPTH entries; up to 2 pushes and 2 pops per cycle.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   bus (slave)   : fetch push side, decode pop side, flush
//   dbg_head_o    : head pointer (read index)
//   dbg_tail_o    : tail pointer (write index)
//   dbg_count_o   : number of valid entries
module ibuf
  import ibuf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  ibuf_if.slave                      bus,
  output logic [$clog2(DEPTH)-1:0]   dbg_head_o,
  output logic [$clog2(DEPTH)-1:0]   dbg_tail_o,
  output logic [$clog2(DEPTH):0]     dbg_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_p1, tail_p1;

  logic [CW-1:0] pop_req, eff_pop, free_after_pop, push_req, push_cnt;
  logic          wr1, wr2;
  ibuf_entry_t   entry1, entry2, rd1, rd2;
  ibuf_entry_t   mem [DEPTH];

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  always_comb begin
    pop_req  = CW'(bus.pop_size);
    // Decode can never take more than is actually present.
    eff_pop  = (pop_req > count_q) ? count_q : pop_req;
    // Space freed by the same-cycle pop is usable by the push, so a full
    // buffer popping 2 still accepts 2.
    free_after_pop = CW'(DEPTH) - count_q + eff_pop;
    push_req = CW'(bus.in_size);
    // Excess beyond free space is dropped; only two write ports exist.
    push_cnt = (push_req > free_after_pop) ? free_after_pop : push_req;
    if (push_cnt > CW'(2)) push_cnt = CW'(2);

    wr1 = !bus.flush && (push_cnt != '0);
    wr2 = !bus.flush && (push_cnt == CW'(2));

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + eff_pop[AW-1:0];
      tail_d  = tail_q + push_cnt[AW-1:0];
      count_d = count_q + push_cnt - eff_pop;
    end
  end

  always_comb begin
    entry1.pc             = bus.in_pc1;
    entry1.inst           = bus.in_inst1;
    entry1.pred_taken     = bus.in_pred_taken1;
    entry1.pred_target    = bus.in_pred_target1;
    entry1.have_exception = bus.in_have_exception;
    entry1.exception_type = bus.in_exception_type;
    // A fetch exception stops the fetch group at slot 1.
    entry2.pc             = bus.in_pc2;
    entry2.inst           = bus.in_inst2;
    entry2.pred_taken     = bus.in_pred_taken2;
    entry2.pred_target    = bus.in_pred_target2;
    entry2.have_exception = 1'b0;
    entry2.exception_type = bus.in_exception_type;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; validity comes only from count_q.
  always_ff @(posedge clk) begin
    if (wr1) mem[tail_q]  <= entry1;
    if (wr2) mem[tail_p1] <= entry2;
  end

  assign rd1 = mem[head_q];
  assign rd2 = mem[head_p1];

  assign bus.ready               = (CW'(DEPTH) - count_q) >= CW'(4);
  assign bus.out_valid1          = count_q >= CW'(1);
  assign bus.out_valid2          = count_q >= CW'(2);
  assign bus.out_pc1             = rd1.pc;
  assign bus.out_pc2             = rd2.pc;
  assign bus.out_inst1           = rd1.inst;
  assign bus.out_inst2           = rd2.inst;
  assign bus.out_pred_taken1     = rd1.pred_taken;
  assign bus.out_pred_taken2     = rd2.pred_taken;
  assign bus.out_pred_target1    = rd1.pred_target;
  assign bus.out_pred_target2    = rd2.pred_target;
  assign bus.out_have_exception1 = rd1.have_exception;
  assign bus.out_have_exception2 = rd2.have_exception;
  assign bus.out_exception_type1 = rd1.exception_type;
  assign bus.out_exception_type2 = rd2.exception_type;

  assign dbg_head_o  = head_q;
  assign dbg_tail_o  = tail_q;
  assign dbg_count_o = count_q;

  // Pushing more than fits (after the same-cycle pop) is a fetch-side bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !bus.flush |-> (CW'(bus.in_size) <= free_after_pop));
  a_legal_in_size: assert property (@(posedge clk) disable iff (!resetn)
    bus.in_size != 2'd3);
  a_legal_pop_size: assert property (@(posedge clk) disable iff (!resetn)
    bus.pop_size != 2'd3);

endmodule

// File: tb/tb_ibuf.sv
module tb_ibuf;
  import ibuf_pkg::*;

  logic       clk;
  logic       resetn;
  logic [3:0] dbg_head, dbg_tail;
  logic [4:0] dbg_count;
  int         total;
  int         bad;

  ibuf_if bus ();

  ibuf #(.DEPTH(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .dbg_head_o  (dbg_head),
    .dbg_tail_o  (dbg_tail),
    .dbg_count_o (dbg_count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one edge, then sit 1 time unit after it for checks/new inputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_size           = 2'd0;
    bus.in_pc1            = '0;
    bus.in_pc2            = '0;
    bus.in_inst1          = '0;
    bus.in_inst2          = '0;
    bus.in_pred_taken1    = 1'b0;
    bus.in_pred_taken2    = 1'b0;
    bus.in_pred_target1   = '0;
    bus.in_pred_target2   = '0;
    bus.in_have_exception = 1'b0;
    bus.in_exception_type = ADEF;
    bus.flush             = 1'b0;
    bus.pop_size          = 2'd0;
  endtask

  // push of size n; slot 2 pc is pc+4; inst words are derived from pc
  task automatic set_push(input logic [1:0] n, input logic [31:0] pc);
    bus.in_size  = n;
    bus.in_pc1   = pc;
    bus.in_pc2   = pc + 32'd4;
    bus.in_inst1 = pc ^ 32'h0280_0000;
    bus.in_inst2 = (pc + 32'd4) ^ 32'h0280_0000;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetn = 1'b0;
    idle();

    // reset
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid1", 32'(bus.out_valid1), 32'd0);
    chk("rst_valid2", 32'(bus.out_valid2), 32'd0);
    chk("rst_count", 32'(dbg_count), 32'd0);

    // single push
    bus.in_size         = 2'd1;
    bus.in_pc1          = 32'h1c00_0000;
    bus.in_inst1        = 32'h0280_0000;
    bus.in_pred_taken1  = 1'b1;
    bus.in_pred_target1 = 32'h1c00_0040;
    tick();
    idle();
    chk("push1_valid1", 32'(bus.out_valid1), 32'd1);
    chk("push1_pc1", bus.out_pc1, 32'h1c00_0000);
    chk("push1_inst1", bus.out_inst1, 32'h0280_0000);
    chk("push1_ptaken1", 32'(bus.out_pred_taken1), 32'd1);
    chk("push1_ptarget1", bus.out_pred_target1, 32'h1c00_0040);
    chk("push1_valid2", 32'(bus.out_valid2), 32'd0);
    chk("push1_tail", 32'(dbg_tail), 32'd1);

    // flush back to empty
    bus.flush = 1'b1;
    tick();
    idle();
    chk("fl0_count", 32'(dbg_count), 32'd0);

    // fill with 2 per cycle, never pop; first push carries an exception
    for (int i = 0; i < 6; i++) begin
      set_push(2'd2, 32'h100 + 32'(8 * i));
      bus.in_have_exception = (i == 0);
      bus.in_exception_type = ADEF;
      tick();
    end
    idle();
    chk("fill6_count", 32'(dbg_count), 32'd12);
    chk("fill6_ready", 32'(bus.ready), 32'd1);
    set_push(2'd2, 32'h130);
    tick();
    idle();
    chk("fill7_count", 32'(dbg_count), 32'd14);
    chk("fill7_ready", 32'(bus.ready), 32'd0);
    chk("fill_pc1", bus.out_pc1, 32'h100);
    chk("fill_pc2", bus.out_pc2, 32'h104);
    chk("fill_exc1", 32'(bus.out_have_exception1), 32'd1);
    chk("fill_etype1", 32'(bus.out_exception_type1), 32'(ADEF));
    chk("fill_exc2", 32'(bus.out_have_exception2), 32'd0);
    set_push(2'd2, 32'h138);
    tick();
    idle();
    chk("full_count", 32'(dbg_count), 32'd16);
    chk("full_tail", 32'(dbg_tail), 32'd0);
    chk("full_ready", 32'(bus.ready), 32'd0);

    // full buffer: pop 2 and push 2 in the same cycle
    set_push(2'd2, 32'h180);
    bus.pop_size = 2'd2;
    tick();
    idle();
    chk("fullpp_count", 32'(dbg_count), 32'd16);
    chk("fullpp_head", 32'(dbg_head), 32'd2);
    chk("fullpp_pc1", bus.out_pc1, 32'h108);

    // steer head to 15 with count 2
    bus.flush = 1'b1;
    tick();
    idle();
    set_push(2'd1, 32'h1f00);
    tick();
    idle();
    bus.pop_size = 2'd1;
    tick();
    idle();
    set_push(2'd2, 32'h1f10);
    tick();
    idle();
    for (int j = 0; j < 7; j++) begin
      set_push(2'd2, 32'h2000 + 32'(8 * j));
      bus.pop_size = 2'd2;
      tick();
    end
    idle();
    chk("wrap_head", 32'(dbg_head), 32'd15);
    chk("wrap_count", 32'(dbg_count), 32'd2);
    chk("wrap_tail", 32'(dbg_tail), 32'd1);
    chk("wrap_pc1_idx15", bus.out_pc1, 32'h2030);
    chk("wrap_pc2_idx0", bus.out_pc2, 32'h2034);
    chk("wrap_inst2_idx0", bus.out_inst2, 32'h2034 ^ 32'h0280_0000);

    set_push(2'd2, 32'h3000);
    bus.pop_size = 2'd2;
    tick();
    idle();
    chk("wpp_head", 32'(dbg_head), 32'd1);
    chk("wpp_count", 32'(dbg_count), 32'd2);
    chk("wpp_pc1", bus.out_pc1, 32'h3000);
    chk("wpp_pc2", bus.out_pc2, 32'h3004);

    // flush mid-stream at count 5
    set_push(2'd2, 32'h3100);
    tick();
    set_push(2'd1, 32'h3200);
    tick();
    idle();
    chk("pre_fl_count", 32'(dbg_count), 32'd5);
    set_push(2'd2, 32'h3300);
    bus.pop_size = 2'd2;
    bus.flush    = 1'b1;
    tick();
    idle();
    chk("fl_count", 32'(dbg_count), 32'd0);
    chk("fl_valid1", 32'(bus.out_valid1), 32'd0);
    chk("fl_ready", 32'(bus.ready), 32'd1);
    chk("fl_head", 32'(dbg_head), 32'd0);

    // exception entry, first post-flush push lands at index 0
    set_push(2'd1, 32'h1c00_0010);
    bus.in_have_exception = 1'b1;
    bus.in_exception_type = PIF;
    tick();
    idle();
    chk("exc_tail", 32'(dbg_tail), 32'd1);
    chk("exc_head", 32'(dbg_head), 32'd0);
    chk("exc_valid1", 32'(bus.out_valid1), 32'd1);
    chk("exc_pc1", bus.out_pc1, 32'h1c00_0010);
    chk("exc_have1", 32'(bus.out_have_exception1), 32'd1);
    chk("exc_type1", 32'(bus.out_exception_type1), 32'(PIF));

    // over-pop
    bus.pop_size = 2'd2;
    tick();
    idle();
    chk("opop_count", 32'(dbg_count), 32'd0);
    chk("opop_head", 32'(dbg_head), 32'd1);
    chk("opop_valid1", 32'(bus.out_valid1), 32'd0);

    // async reset mid-cycle
    set_push(2'd2, 32'h4000);
    tick();
    idle();
    chk("pre_ar_valid1", 32'(bus.out_valid1), 32'd1);
    chk("pre_ar_pc1", bus.out_pc1, 32'h4000);
    #3;
    resetn = 1'b0;
    #1;
    chk("ar_valid1", 32'(bus.out_valid1), 32'd0);
    chk("ar_count", 32'(dbg_count), 32'd0);
    chk("ar_head", 32'(dbg_head), 32'd0);
    chk("ar_ready", 32'(bus.ready), 32'd1);
    tick();
    resetn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
